// File: rtl/calc_ctrl_p.sv
// Calculator controller with a decimal operand builder, a one-cycle add/sub/mul and chained operations.
// Define CALC_DIV_EN to compile in the iterative restoring divider. Without it, op=3 is ignored.
module calc_ctrl_p #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic             eq_valid,
  input  logic             clr,
  output logic [1:0]       salida,
  output logic [WIDTH-1:0] display,
  output logic             error,
  output logic             busy
);
  typedef enum logic [1:0] {S_NUM1 = 2'd0, S_NUM2 = 2'd1, S_SHOW = 2'd2, S_ERR = 2'd3} state_t;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_a, r_b, r_disp, w_a_nx, w_b_nx, w_disp_nx;
  logic [1:0]       r_op, w_op_nx;

  logic [WIDTH-1:0]   w_cur, w_res;
  logic [WIDTH+3:0]   w_ext;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_dig_ok, w_dig_fit, w_op_ok, w_err, w_chain;

`ifdef CALC_DIV_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic             r_busy, r_chain, w_busy_nx, w_chain_nx, w_ge;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvsr, w_rem_nx, w_quo_nx, w_quo_it, w_dvsr_nx;
  logic [WIDTH:0]   w_rem_sh;
  logic [1:0]       r_nop, w_nop_nx;
`endif

  // Operand being typed, shifted one decimal place with the new digit appended
  assign w_cur     = (r_state == S_NUM2) ? r_b : r_a;
  assign w_ext     = {4'd0, w_cur} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, digit};
  assign w_dig_ok  = digit_valid && (digit <= 4'd9);
  assign w_dig_fit = (w_ext[WIDTH+3:WIDTH] == 4'd0);
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_prod    = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
`ifdef CALC_DIV_EN
  assign w_op_ok   = op_valid;
`else
  assign w_op_ok   = op_valid && (op != OP_DIV);
`endif

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (r_op)
      OP_ADD: begin w_res = w_sum[WIDTH-1:0];  w_err = w_sum[WIDTH]; end
      OP_SUB: begin w_res = r_a - r_b;         w_err = (r_b > r_a); end
      OP_MUL: begin w_res = w_prod[WIDTH-1:0]; w_err = |w_prod[2*WIDTH-1:WIDTH]; end
      default: w_err = (r_b == '0);
    endcase
  end

`ifdef CALC_DIV_EN
  // One restoring step: bring down the next dividend bit, subtract if it fits
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvsr});
  assign w_quo_it = {r_quo[WIDTH-2:0], w_ge};
`endif

  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_op_nx    = r_op;
    w_disp_nx  = r_disp;
    w_chain    = 1'b0;
`ifdef CALC_DIV_EN
    w_busy_nx  = r_busy;
    w_chain_nx = r_chain;
    w_cnt_nx   = r_cnt;
    w_rem_nx   = r_rem;
    w_quo_nx   = r_quo;
    w_dvsr_nx  = r_dvsr;
    w_nop_nx   = r_nop;
`endif
    if (clr) begin
      w_state_nx = S_NUM1;
      w_a_nx     = '0;
      w_b_nx     = '0;
      w_op_nx    = OP_ADD;
      w_disp_nx  = '0;
`ifdef CALC_DIV_EN
      w_busy_nx  = 1'b0;
    end else if (r_busy) begin
      w_cnt_nx = r_cnt + 1'b1;
      w_rem_nx = WIDTH'(w_ge ? (w_rem_sh - {1'b0, r_dvsr}) : w_rem_sh);
      w_quo_nx = w_quo_it;
      if (r_cnt == CW'(WIDTH-1)) begin
        w_busy_nx  = 1'b0;
        w_a_nx     = w_quo_it;
        w_b_nx     = '0;
        w_disp_nx  = w_quo_it;
        w_state_nx = r_chain ? S_NUM2 : S_SHOW;
        if (r_chain) w_op_nx = r_nop;
      end
`endif
    end else begin
      case (r_state)
        S_NUM1: begin
          if (eq_valid) begin
            w_state_nx = r_state;
          end else if (op_valid) begin
            if (w_op_ok) begin
              w_op_nx    = op;
              w_b_nx     = '0;
              w_state_nx = S_NUM2;
            end
          end else if (w_dig_ok && w_dig_fit) begin
            w_a_nx    = w_ext[WIDTH-1:0];
            w_disp_nx = w_ext[WIDTH-1:0];
          end
        end
        S_NUM2: begin
          if (eq_valid || w_op_ok) begin
            w_chain = !eq_valid;
            if (w_err) begin
              w_state_nx = S_ERR;
              w_disp_nx  = '0;
`ifdef CALC_DIV_EN
            end else if (r_op == OP_DIV) begin
              w_busy_nx  = 1'b1;
              w_cnt_nx   = '0;
              w_rem_nx   = '0;
              w_quo_nx   = r_a;
              w_dvsr_nx  = r_b;
              w_chain_nx = w_chain;
              w_nop_nx   = op;
`endif
            end else begin
              w_a_nx     = w_res;
              w_b_nx     = '0;
              w_disp_nx  = w_res;
              w_state_nx = w_chain ? S_NUM2 : S_SHOW;
              if (w_chain) w_op_nx = op;
            end
          end else if (!op_valid && w_dig_ok && w_dig_fit) begin
            w_b_nx    = w_ext[WIDTH-1:0];
            w_disp_nx = w_ext[WIDTH-1:0];
          end
        end
        S_SHOW: begin
          if (eq_valid) begin
            w_state_nx = r_state;
          end else if (op_valid) begin
            if (w_op_ok) begin
              w_op_nx    = op;
              w_b_nx     = '0;
              w_state_nx = S_NUM2;
            end
          end else if (w_dig_ok) begin
            w_a_nx     = {{(WIDTH-4){1'b0}}, digit};
            w_disp_nx  = {{(WIDTH-4){1'b0}}, digit};
            w_state_nx = S_NUM1;
          end
        end
        default: w_state_nx = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_NUM1;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_disp  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_op    <= w_op_nx;
      r_disp  <= w_disp_nx;
    end
  end

`ifdef CALC_DIV_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_chain <= 1'b0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_nop   <= OP_ADD;
    end else begin
      r_busy  <= w_busy_nx;
      r_chain <= w_chain_nx;
      r_cnt   <= w_cnt_nx;
      r_rem   <= w_rem_nx;
      r_quo   <= w_quo_nx;
      r_dvsr  <= w_dvsr_nx;
      r_nop   <= w_nop_nx;
    end
  end
  assign busy = r_busy;
`else
  assign busy = 1'b0;
`endif

  assign salida  = r_state;
  assign display = r_disp;
  assign error   = (r_state == S_ERR);
endmodule

// File: doc/calc_ctrl_p.md
# calc_ctrl_p

Parametrised calculator controller with an integrated datapath. It is the successor to the three-state operand/operator FSM. Digits, operators, equals and clear arrive as single-cycle strobes. The block assembles decimal operands into a WIDTH-bit unsigned accumulator, supports chained operations, and computes add/sub/mul in one cycle and division iteratively. It reports the control state, the displayed value and error/busy flags to the display driver.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits (unsigned), minimum 4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- digit_valid  in  1  strobe: `digit` is valid this cycle.
- digit  in  4  decimal digit 0–9; values 10–15 are ignored.
- op_valid  in  1  strobe: `op` is valid this cycle.
- op  in  2  operator code: 0 = add, 1 = sub, 2 = mul, 3 = div.
- eq_valid  in  1  equals strobe.
- clr  in  1  clear strobe.
- salida  out  2  control state: 0 = WAIT_NUM1, 1 = WAIT_NUM2, 2 = SHOW_RESULT, 3 = ERROR.
- display  out  WIDTH  operand being entered, or the last result.
- error  out  1  high while in ERROR.
- busy  out  1  high while a division is in progress.

## Operation
- Reset: salida=0, display=0, error=0, busy=0; operand A, operand B and the latched op are cleared.
- Priority for simultaneous strobes in one cycle: clr > eq_valid > op_valid > digit_valid. Only the highest-priority strobe takes effect.
- clr, in any state (including during busy): performs the same action as reset, to WAIT_NUM1 with display=0.
- Digit entry (WAIT_NUM1 updates A, WAIT_NUM2 updates B):
  - New value = value*10 + digit.
  - If the new value exceeds 2^WIDTH−1, the digit is dropped and the value is unchanged.
  - display tracks the operand being entered.
- WAIT_NUM1:
  - op_valid: latch op, B=0, go to WAIT_NUM2. display keeps showing A.
  - eq_valid: ignored.
- WAIT_NUM2:
  - op_valid (chaining): compute A op B. The result becomes A, the new op is latched, B=0, state stays WAIT_NUM2, display=result.
  - eq_valid: compute A op B, go to SHOW_RESULT, display=result.
  - If no digit was entered, B=0.
- SHOW_RESULT:
  - op_valid: result becomes A, latch op, B=0, go to WAIT_NUM2.
  - digit_valid: A=digit, go to WAIT_NUM1.
  - eq_valid: ignored.
- ERROR conditions, all going to state 3 with error=1 and display=0:
  - add or mul result > 2^WIDTH−1;
  - sub with B > A;
  - div with B = 0.
- ERROR: only clr or rst leaves it; all other strobes are ignored.
- Arithmetic is unsigned. mul uses a 2·WIDTH-bit product checked for upper-half nonzero. div is truncating (quotient only).

## Timing
- Digit and operator strobes take effect on the next rising edge; display and salida update one cycle after the strobe.
- add/sub/mul: the result and the new salida are registered one cycle after the triggering eq_valid/op_valid.
- div: busy rises the cycle after the trigger and stays high exactly WIDTH cycles, using a restoring shift-subtract of one bit per cycle. In the cycle busy falls, display, salida and the new op (if chained) are updated.
- Division by zero is detected at the trigger: go to ERROR next cycle, busy never asserted.
- While busy=1, all strobes except clr are ignored (not queued). clr or rst mid-division aborts it; busy=0 next cycle.

## Configuration
- CALC_DIV_EN defined: division and its iterative divider are compiled in, as described above.
- CALC_DIV_EN undefined:
  - No divider logic is present and busy is tied to 0.
  - op_valid with op=3 is ignored in every state: no state change and no op latch.

## Test plan
- WIDTH=16: digits 1,2; op add; digits 3,4; eq -> display=46, salida=2, error=0 one cycle after eq.
- Chain: 5, mul, 6, sub (intermediate display=30, salida=1), 3, eq -> display=27, salida=2.
- Overflow: 65535, add, 1, eq -> salida=3, error=1, display=0. Then digit 7 is ignored; then clr -> salida=0, error=0.
- Digit saturation: digits 7,0,0,0,0 -> display=7000 after the fourth digit and still 7000 after the fifth. Simultaneous clr+digit -> display=0.
- CALC_DIV_EN:
  - 100, div, 7, eq -> busy high exactly 16 cycles, then display=14, salida=2.
  - 5, div, eq -> ERROR next cycle with busy never asserted.
  - rst asserted at cycle 8 of a division -> all outputs 0 next cycle.
- Without CALC_DIV_EN: 9, op=3 -> salida stays 0 and display stays 9; a subsequent add still works normally.
